// File: rtl/fsk_pkg.sv
// fsk_pkg
// Shared definitions for the FSK astable generator: FSM state encoding,
// operating-mode encoding and the default phase-counter width.
package fsk_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  // Operating mode
  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Default width of phase-length inputs and the phase counter
  localparam int CNT_W_DEF = 32;

endpackage : fsk_pkg

// File: rtl/fsk_astavel_gen.sv
// fsk_astavel_gen
// Square-wave generator with independently programmable low/high phase
// lengths, two selectable tone profiles, continuous and one-shot modes, and
// single-cycle edge ticks.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-high reset
//   en         run enable
//   mode       0 = continuous, 1 = one-shot
//   start      one-shot trigger (only honoured in IDLE with en=1, mode=1)
//   sel        tone profile select
//   low0/high0 profile-0 low/high phase lengths (clk cycles)
//   low1/high1 profile-1 low/high phase lengths (clk cycles)
//   clk_out    generated waveform (registered)
//   rise_tick  pulse in the first high cycle
//   fall_tick  pulse in the first low cycle following a high phase
//   busy       generator is not idle
module fsk_astavel_gen
  import fsk_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit ONE_AS_MIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             sel,
  input  logic [CNT_W-1:0] low0,
  input  logic [CNT_W-1:0] high0,
  input  logic [CNT_W-1:0] low1,
  input  logic [CNT_W-1:0] high1,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy
);

  // Terminal count for a programmed length. A length of 0 becomes either a
  // single cycle or a full 2**CNT_W cycles; in the latter case the terminal
  // value is all-ones and the counter simply runs through its whole range.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] len);
    if (len == '0) begin
      last_cnt = ONE_AS_MIN ? '0 : '1;
    end else begin
      last_cnt = len - 1'b1;
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lo_s_q, lo_s_d;
  logic [CNT_W-1:0] hi_s_q, hi_s_d;

  logic clk_out_q, clk_out_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic busy_q, busy_d;

  // Profile currently selected on the inputs; only sampled on LOW entry.
  logic [CNT_W-1:0] lo_sel, hi_sel;
  assign lo_sel = sel ? low1  : low0;
  assign hi_sel = sel ? high1 : high0;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lo_s_q  <= '0;
      hi_s_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_s_q  <= lo_s_d;
      hi_s_q  <= hi_s_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_s_d  = lo_s_q;
    hi_s_d  = hi_s_q;
    case (state_q)
      ST_IDLE: begin
        if (en && (mode == MODE_CONT || start)) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          lo_s_d  = lo_sel;
          hi_s_d  = hi_sel;
        end
      end
      ST_LOW: begin
        if (cnt_q == last_cnt(lo_s_q)) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == last_cnt(hi_s_q)) begin
          cnt_d = '0;
          // Mode and enable are only consulted here, at the period boundary,
          // so a period is never truncated.
          if (en && mode == MODE_CONT) begin
            state_d = ST_LOW;
            lo_s_d  = lo_sel;
            hi_s_d  = hi_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: decoded from the upcoming state so the registered outputs
  // line up with the state register on the same edge.
  always_comb begin
    clk_out_d = (state_d == ST_HIGH);
    busy_d    = (state_d != ST_IDLE);
    rise_d    = (state_q == ST_LOW)  && (state_d == ST_HIGH);
    fall_d    = (state_q == ST_HIGH) && (state_d != ST_HIGH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign busy      = busy_q;

endmodule : fsk_astavel_gen

// File: tb/tb_fsk_astavel_gen.sv
// tb_fsk_astavel_gen
// Directed testbench for fsk_astavel_gen. Outputs are sampled on the falling
// edge; inputs are changed on the falling edge too, away from the active edge.
module tb_fsk_astavel_gen;
  import fsk_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       start;
  logic       sel;
  logic [7:0] low0, high0, low1, high1;
  logic [2:0] low0_b, high0_b;

  logic co_a, rt_a, ft_a, bz_a;
  logic co_b, rt_b, ft_b, bz_b;

  logic use_b;
  logic obs_co, obs_rt, obs_ft, obs_bz;

  int chk_cnt;
  int err_cnt;

  // Main instance: 8-bit lengths, zero treated as one cycle
  fsk_astavel_gen #(.CNT_W(8), .ONE_AS_MIN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .start     (start),
    .sel       (sel),
    .low0      (low0),
    .high0     (high0),
    .low1      (low1),
    .high1     (high1),
    .clk_out   (co_a),
    .rise_tick (rt_a),
    .fall_tick (ft_a),
    .busy      (bz_a)
  );

  // Second instance: 3-bit lengths, zero treated as 2**3 cycles
  fsk_astavel_gen #(.CNT_W(3), .ONE_AS_MIN(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .start     (start),
    .sel       (sel),
    .low0      (low0_b),
    .high0     (high0_b),
    .low1      (low1[2:0]),
    .high1     (high1[2:0]),
    .clk_out   (co_b),
    .rise_tick (rt_b),
    .fall_tick (ft_b),
    .busy      (bz_b)
  );

  assign obs_co = use_b ? co_b : co_a;
  assign obs_rt = use_b ? rt_b : rt_a;
  assign obs_ft = use_b ? ft_b : ft_a;
  assign obs_bz = use_b ? bz_b : bz_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check n consecutive cycles; bit vectors are written in time order
  // (leftmost literal bit = first cycle).
  task automatic run_seq(input string tag, input int n,
                         input logic [31:0] co_v, input logic [31:0] rt_v,
                         input logic [31:0] ft_v, input logic [31:0] bz_v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s.clk_out[%0d]", tag, i), {31'd0, obs_co}, {31'd0, co_v[n-1-i]});
      chk($sformatf("%s.rise[%0d]", tag, i),    {31'd0, obs_rt}, {31'd0, rt_v[n-1-i]});
      chk($sformatf("%s.fall[%0d]", tag, i),    {31'd0, obs_ft}, {31'd0, ft_v[n-1-i]});
      chk($sformatf("%s.busy[%0d]", tag, i),    {31'd0, obs_bz}, {31'd0, bz_v[n-1-i]});
      $display("%s cycle %0d: clk_out=%0b rise=%0b fall=%0b busy=%0b",
               tag, i, obs_co, obs_rt, obs_ft, obs_bz);
    end
  endtask

  // Reset held across two rising edges; released on a falling edge so the
  // next rising edge is the first functional one.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    use_b   = 1'b0;
    rst     = 1'b1;
    en      = 1'b0;
    mode    = MODE_CONT;
    start   = 1'b0;
    sel     = 1'b0;
    low0    = 8'd0;
    high0   = 8'd0;
    low1    = 8'd0;
    high1   = 8'd0;
    low0_b  = 3'd0;
    high0_b = 3'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.clk_out", {31'd0, co_a}, 32'd0);
    chk("rst.rise",    {31'd0, rt_a}, 32'd0);
    chk("rst.fall",    {31'd0, ft_a}, 32'd0);
    chk("rst.busy",    {31'd0, bz_a}, 32'd0);

    // Continuous 3/2
    en = 1'b1; mode = MODE_CONT; sel = 1'b0; low0 = 8'd3; high0 = 8'd2;
    do_reset();
    run_seq("cont", 12, 12'b000110001100, 12'b000100001000,
                        12'b000001000010, 12'b111111111111);

    // Tone switch during the second HIGH cycle of the first period
    low1 = 8'd1; high1 = 8'd1;
    do_reset();
    run_seq("tone_a", 5, 5'b00011, 5'b00010, 5'b00000, 5'b11111);
    sel = 1'b1;
    run_seq("tone_b", 6, 6'b010101, 6'b010101, 6'b101010, 6'b111111);

    // Zero lengths with zero-as-one
    sel = 1'b0; low0 = 8'd0; high0 = 8'd0;
    do_reset();
    run_seq("zero", 7, 7'b0101010, 7'b0101010, 7'b0010101, 7'b1111111);

    // One-shot 2/2 with a second start while busy
    mode = MODE_ONESHOT; low0 = 8'd2; high0 = 8'd2; start = 1'b0;
    do_reset();
    run_seq("os_idle", 2, 2'b00, 2'b00, 2'b00, 2'b00);
    start = 1'b1;
    run_seq("os_0", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    run_seq("os_1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    run_seq("os_2", 1, 1'b1, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    run_seq("os_3", 5, 5'b10000, 5'b00000, 5'b01000, 5'b10000);

    // Enable dropped in the second LOW cycle of a 4/4 period
    mode = MODE_CONT; low0 = 8'd4; high0 = 8'd4;
    do_reset();
    run_seq("endrop_a", 2, 2'b00, 2'b00, 2'b00, 2'b11);
    en = 1'b0;
    run_seq("endrop_b", 8, 8'b00111100, 8'b00100000, 8'b00000010, 8'b11111100);

    // Asynchronous reset in the middle of a HIGH phase
    en = 1'b1; low0 = 8'd3; high0 = 8'd2;
    do_reset();
    run_seq("arst_pre", 4, 4'b0001, 4'b0001, 4'b0000, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.clk_out", {31'd0, co_a}, 32'd0);
    chk("arst.rise",    {31'd0, rt_a}, 32'd0);
    chk("arst.fall",    {31'd0, ft_a}, 32'd0);
    chk("arst.busy",    {31'd0, bz_a}, 32'd0);
    $display("arst mid-high: clk_out=%0b rise=%0b fall=%0b busy=%0b", co_a, rt_a, ft_a, bz_a);
    low0 = 8'd2; high0 = 8'd1;
    @(negedge clk);
    rst = 1'b0;
    run_seq("arst_post", 6, 6'b001001, 6'b001001, 6'b000100, 6'b111111);

    // Zero length as full counter range (3-bit instance: 8 low, 1 high)
    use_b = 1'b1; sel = 1'b0; low0_b = 3'd0; high0_b = 3'd1;
    do_reset();
    run_seq("fullrange", 11, 11'b00000000100, 11'b00000000100,
                             11'b00000000010, 11'b11111111111);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_fsk_astavel_gen
